ethernet_udp_receive: RTL and testbench
=======================================

# ethernet_udp_receive

Receive-side counterpart of the UDP transmit path. It consumes an MII receive nibble stream that has already been brought into the system clock domain and qualified by a strobe. It parses the Ethernet, IPv4 and UDP headers, filters frames addressed to this node, and captures a fixed-size payload. It then presents the payload and the sender's addressing (IPInfo) with a one-cycle valid or error pulse, so the top level can echo or act on received datagrams.

## Interface
- `DATA_BYTES`, 256: fixed UDP payload length accepted; must be >= 18 (no Ethernet padding).
- `clk` input 1: system clock.
- `rstn` input 1: asynchronous, active-low reset.
- `rx_strobe` input 1: high for one clk per received nibble.
- `rx_dv` input 1: MII data valid, meaningful only when `rx_strobe`=1.
- `rx_d` input 4: MII nibble, low nibble of each byte first.
- `local_mac` input 48: MAC address to accept; ff:ff:ff:ff:ff:ff is also accepted.
- `local_ip` input 32: IPv4 destination address to accept.
- `local_port` input 16: UDP destination port to accept.
- `data` output 8*DATA_BYTES: payload; first received byte in `data[8*DATA_BYTES-1 -: 8]`.
- `ip_info` output IPInfo: sender's src_mac/src_ip/src_port; dest_* fields are the matched local values.
- `valid` output 1: one-cycle pulse when a frame is accepted.
- `error` output 1: one-cycle pulse when a frame that matched the filters so far is truncated, overlong or (optionally) fails CRC.
- `busy` output 1: high from SFD detection until the frame ends.

## Operation
- All state advances only on cycles with `rx_strobe`=1.
- Bytes are assembled from nibble pairs: low nibble first, then high.
- Multi-byte header fields are big-endian on the wire.
- States:
  - IDLE: waits for `rx_dv`=1, then goes to PREAMBLE.
  - PREAMBLE: consumes nibbles 0x5. Nibble 0xD after at least one 0x5 (the SFD) goes to HEADER; any other nibble goes to DROP.
  - HEADER: 42 bytes, tracked by byte counter 0..41.
  - PAYLOAD: DATA_BYTES bytes.
  - FCS: 4 bytes.
  - DROP: waits for `rx_dv`=0, then goes to IDLE.
- Header checks, each evaluated on its last byte; any mismatch goes to DROP silently (no `error`):
  - dest MAC (bytes 0-5) equals `local_mac` or broadcast.
  - ethertype (12-13) = 0x0800.
  - byte 14 = 0x45.
  - protocol (23) = 0x11.
  - dest IP (30-33) = `local_ip`.
  - dest port (36-37) = `local_port`.
  - UDP length (38-39) = 8+DATA_BYTES.
- Captured into `ip_info` during HEADER: src MAC (bytes 6-11), src IP (26-29), src port (34-35).
- IP header checksum and UDP checksum are not verified.
- Frame end:
  - `rx_dv`=0 seen in PAYLOAD or FCS, or mid-byte (odd nibble) → `error`, then IDLE.
  - `rx_dv`=1 after the 4th FCS byte → DROP with `error`.
  - `rx_dv`=0 on the first strobe after the 4th FCS byte → `valid` (or `error` on CRC failure), then IDLE.
- `data` shifts in during PAYLOAD. It is meaningful only at `valid` and is stable until the next accepted frame reaches PAYLOAD.
- Reset values: `data`='0, `ip_info`='0, `valid`=0, `error`=0, `busy`=0, state IDLE, counters 0.
- Asserting `rstn` mid-frame aborts the frame without a pulse.
- After reset is released while `rx_dv` is already high, the block waits in DROP for `rx_dv`=0 before accepting a new frame.

## Timing
- `valid`/`error` are registered: they are high exactly one clk, in the cycle after the strobe that resolved the frame.
- `valid` and `error` are never high together.
- `busy` rises the clk after the SFD strobe and falls in the same cycle as the `valid`/`error` pulse, or on entry to DROP.
- No back-pressure; the block keeps up with strobes on consecutive clks.
- Back-to-back frames: IDLE accepts `rx_dv`=1 on the strobe immediately after the end-of-frame strobe.

## Configuration
- `ETH_RX_CRC_CHECK_EN` defined:
  - A CRC-32 runs over all bytes from dest MAC through FCS, nibble-wise: reflected polynomial 0x04C11DB7, init 0xFFFFFFFF.
  - At frame end the residue must equal 0xC704DD7B; otherwise `error` is pulsed instead of `valid`.
- Undefined: no CRC logic is built, and the FCS bytes are counted but ignored.

## Structure
- Shared ethernet package:
  - existing IPInfo typedef,
  - constants ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'h11, ETH_HEADER_BYTES=42, CRC_RESIDUE,
  - rx state enum.
- One sub-module, `crc32_nibble`: combinational next-CRC from (crc, nibble). It is instantiated only under `ETH_RX_CRC_CHECK_EN`.

## Test plan
- Well-formed frame, DATA_BYTES=256, payload 0x00..0xFF, dest port matching `local_port`, correct FCS → one `valid`; `data[2047:2040]`=0x00, `data[7:0]`=0xFF; `ip_info` holds the sender's MAC/IP/port.
- Same frame with dest IP off by one → no `valid`, no `error`, `busy` falls; an immediate second good frame → `valid`.
- Broadcast dest MAC with correct IP/port → `valid`.
- `rx_dv` dropped after 100 payload bytes → one `error`, no `valid`.
- With `ETH_RX_CRC_CHECK_EN`, one FCS bit flipped → `error`. Without the macro, same frame → `valid`.
- `rstn` asserted during PAYLOAD and released while `rx_dv`=1 → outputs zero; frame ignored; next frame → `valid`.

Source files
------------

// File: rtl/ethernet_udp_receive_pkg.sv
// ethernet_udp_receive_pkg: shared Ethernet/IPv4/UDP addressing types, protocol constants and rx state enum.
package ethernet_udp_receive_pkg;
  typedef struct packed {
    logic [47:0] src_mac;
    logic [47:0] dest_mac;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [15:0] src_port;
    logic [15:0] dest_port;
  } IPInfo;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;
  localparam int ETH_HEADER_BYTES = 42;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  typedef enum logic [2:0] {RX_IDLE, RX_PREAMBLE, RX_HEADER, RX_PAYLOAD, RX_FCS, RX_DROP} rx_state_t;
endpackage

// File: rtl/ethernet_udp_receive_crc32_nibble.sv
// crc32_nibble: combinational reflected CRC-32 step over one nibble, LSB first.
module crc32_nibble (
  input  logic [31:0] crc,
  input  logic [3:0]  nibble,
  output logic [31:0] crc_next
);
  always_comb begin
    crc_next = crc ^ {28'd0, nibble};
    for (int i = 0; i < 4; i++) crc_next = crc_next[0] ? (crc_next >> 1) ^ 32'hEDB88320 : crc_next >> 1;
  end
endmodule

// File: rtl/ethernet_udp_receive.sv
// ethernet_udp_receive: MII nibble-stream UDP receiver with MAC/IP/port filtering and fixed-size payload capture.
// Defining ETH_RX_CRC_CHECK_EN adds FCS verification; otherwise the FCS bytes are only counted.
module ethernet_udp_receive
  import ethernet_udp_receive_pkg::*;
#(
  parameter int DATA_BYTES = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    rx_strobe,
  input  logic                    rx_dv,
  input  logic [3:0]              rx_d,
  input  logic [47:0]             local_mac,
  input  logic [31:0]             local_ip,
  input  logic [15:0]             local_port,
  output logic [8*DATA_BYTES-1:0] data,
  output IPInfo                   ip_info,
  output logic                    valid,
  output logic                    error,
  output logic                    busy
);
  localparam int CW = $clog2(DATA_BYTES) + 1;
  localparam logic [CW-1:0] LAST_HDR = CW'(ETH_HEADER_BYTES - 1);
  localparam logic [CW-1:0] LAST_PAY = CW'(DATA_BYTES - 1);
  localparam logic [15:0] UDP_LEN = 16'(8 + DATA_BYTES);
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] lo;
  logic odd, seen5, last_dv, hdr_ok, crc_ok;
  logic [47:0] sh, sh_n;
  logic [7:0] rx_byte;
  int idx;
  assign idx = int'(cnt);
  assign rx_byte = {rx_d, lo};
  assign sh_n = {sh[39:0], rx_byte};
  assign hdr_ok = idx == 5  ? (sh_n == local_mac || &sh_n) :
                  idx == 13 ? sh_n[15:0] == ETHERTYPE_IPV4 :
                  idx == 14 ? rx_byte == 8'h45 :
                  idx == 23 ? rx_byte == IP_PROTO_UDP :
                  idx == 33 ? sh_n[31:0] == local_ip :
                  idx == 37 ? sh_n[15:0] == local_port :
                  idx == 39 ? sh_n[15:0] == UDP_LEN : 1'b1;
`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc, crc_next, crc_rev;
  crc32_nibble u_crc (.crc(crc), .nibble(rx_d), .crc_next(crc_next));
  assign crc_rev = {<<{crc}};
  assign crc_ok = crc_rev == CRC_RESIDUE;
  // preamble nibbles keep reseeding, so the first header nibble starts from all-ones
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) crc <= '1;
    else if (rx_strobe && rx_dv) crc <= state == RX_PREAMBLE ? '1 : crc_next;
`else
  assign crc_ok = 1'b1;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      lo      <= '0;
      odd     <= 1'b0;
      seen5   <= 1'b0;
      last_dv <= 1'b1;
      sh      <= '0;
      data    <= '0;
      ip_info <= '0;
      valid   <= 1'b0;
      error   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      if (rx_strobe) begin
        last_dv <= rx_dv;
        if (rx_dv) begin
          lo  <= rx_d;
          odd <= !odd;
        end
        case (state)
          // a stream already in flight (dv high on the previous strobe) is never entered mid-frame
          RX_IDLE: if (rx_dv) begin
            state <= last_dv ? RX_DROP : RX_PREAMBLE;
            seen5 <= rx_d == 4'h5;
          end
          RX_PREAMBLE:
            if (rx_dv && rx_d == 4'h5) seen5 <= 1'b1;
            else if (rx_dv && rx_d == 4'hD && seen5) begin
              state <= RX_HEADER;
              busy  <= 1'b1;
              cnt   <= '0;
              odd   <= 1'b0;
            end else state <= RX_DROP;
          RX_DROP: if (!rx_dv) state <= RX_IDLE;
          default:
            if (state == RX_FCS && idx == 4) begin
              state <= rx_dv ? RX_DROP : RX_IDLE;
              busy  <= 1'b0;
              valid <= !rx_dv && crc_ok;
              error <= rx_dv || !crc_ok;
            end else if (!rx_dv) begin
              state <= RX_IDLE;
              busy  <= 1'b0;
              error <= odd || state != RX_HEADER;
            end else if (odd) begin
              cnt <= cnt + 1'b1;
              if (state == RX_HEADER) begin
                sh <= sh_n;
                if (idx == 11) ip_info.src_mac <= sh_n;
                if (idx == 29) ip_info.src_ip <= sh_n[31:0];
                if (idx == 35) ip_info.src_port <= sh_n[15:0];
                if (idx == 41) begin
                  ip_info.dest_mac  <= local_mac;
                  ip_info.dest_ip   <= local_ip;
                  ip_info.dest_port <= local_port;
                end
                if (!hdr_ok) begin
                  state <= RX_DROP;
                  busy  <= 1'b0;
                end else if (cnt == LAST_HDR) begin
                  state <= RX_PAYLOAD;
                  cnt   <= '0;
                end
              end else if (state == RX_PAYLOAD) begin
                data <= {data[8*DATA_BYTES-9:0], rx_byte};
                if (cnt == LAST_PAY) begin
                  state <= RX_FCS;
                  cnt   <= '0;
                end
              end
            end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ethernet_udp_receive.sv
// tb_ethernet_udp_receive: scoreboard bench for the UDP receiver; CRC expectations follow ETH_RX_CRC_CHECK_EN.
module tb_ethernet_udp_receive;
  import ethernet_udp_receive_pkg::*;
  localparam int DB = 256;
  localparam int NONE = 99999;
  localparam logic [47:0] SRC_MAC = 48'h0A_BB_CC_DD_EE_01;
  localparam logic [31:0] SRC_IP = 32'hC0A8_0105;
  localparam logic [15:0] SRC_PORT = 16'd1234;
  logic clk = 1'b0, rstn = 1'b0, rx_strobe = 1'b0, rx_dv = 1'b0, gap = 1'b0;
  logic [3:0] rx_d = 4'h0;
  logic [47:0] local_mac = 48'h02_11_22_33_44_55;
  logic [31:0] local_ip = 32'hC0A8_010A;
  logic [15:0] local_port = 16'd5000;
  logic [8*DB-1:0] data, pay_model;
  IPInfo ip_info;
  logic valid, error, busy;
  int checks = 0, failures = 0;
  typedef struct {
    logic [1:0] kind;
    logic [8*DB-1:0] data;
    IPInfo info;
  } ev_t;
  ev_t exp_q[$], obs_q[$];

  ethernet_udp_receive #(.DATA_BYTES(DB)) dut (
    .clk(clk), .rstn(rstn), .rx_strobe(rx_strobe), .rx_dv(rx_dv), .rx_d(rx_d),
    .local_mac(local_mac), .local_ip(local_ip), .local_port(local_port),
    .data(data), .ip_info(ip_info), .valid(valid), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (valid || error) obs_q.push_back('{{valid, error}, data, ip_info});

  function automatic IPInfo exp_info();
    IPInfo i;
    i.src_mac = SRC_MAC;
    i.dest_mac = local_mac;
    i.src_ip = SRC_IP;
    i.dest_ip = local_ip;
    i.src_port = SRC_PORT;
    i.dest_port = local_port;
    return i;
  endfunction

  task automatic strobe(input logic dv, input logic [3:0] d);
    rx_strobe = 1'b1;
    rx_dv = dv;
    rx_d = d;
    @(posedge clk);
    #1;
    if (gap) begin
      rx_strobe = 1'b0;
      rx_dv = 1'($urandom);
      rx_d = 4'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic take(output ev_t o, output int n);
    n = obs_q.size();
    o = '{2'b00, '0, '0};
    if (n != 0) o = obs_q.pop_front();
  endtask

  task automatic send_frame(input logic [47:0] dmac, input logic [31:0] dip, input int flip,
                            input int trunc, input int rst_at, output logic busy_mid);
    logic [335:0] hdr;
    logic [7:0] fr[$];
    logic [31:0] c;
    hdr = {dmac, SRC_MAC, ETHERTYPE_IPV4, 8'h45, 8'h00, 16'(28 + DB), 16'h1C46, 16'h4000,
           8'h40, IP_PROTO_UDP, 16'h0000, SRC_IP, dip, SRC_PORT, local_port, 16'(8 + DB), 16'h0000};
    for (int i = 0; i < 42; i++) fr.push_back(hdr[335 - 8*i -: 8]);
    for (int i = 0; i < DB; i++) fr.push_back(8'(i));
    c = '1;
    foreach (fr[k]) begin
      c ^= {24'd0, fr[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    c = ~c;
    for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
    if (flip >= 0) fr[42 + DB + flip / 8] ^= 8'(1 << (flip % 8));
    busy_mid = 1'b0;
    for (int i = 0; i < 15; i++) strobe(1'b1, 4'h5);
    strobe(1'b1, 4'hD);
    for (int j = 0; j < fr.size(); j++) begin
      if (j == 42 + trunc) break;
      if (j == 52) busy_mid = busy;
      if (j == 42 + rst_at) rstn = 1'b0;
      strobe(1'b1, fr[j][3:0]);
      strobe(1'b1, fr[j][7:4]);
      if (j == 42 + rst_at) rstn = 1'b1;
    end
    strobe(1'b0, 4'h0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", error); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (data !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", data[31:0]); end
    if (ip_info !== '0) begin failures++; $display("FAIL reset_ip_info: got %h want 0", ip_info); end
    rstn = 1'b1;
    strobe(1'b0, 4'h0);
    strobe(1'b0, 4'h0);
  endtask

  task automatic test_good();
    ev_t e, o;
    int n;
    logic bm;
    exp_q.push_back('{2'b10, pay_model, exp_info()});
    send_frame(local_mac, local_ip, -1, NONE, NONE, bm);
    settle();
    e = exp_q.pop_front();
    take(o, n);
    checks += 8;
    if (n != 1) begin failures++; $display("FAIL good_count: got %0d pulses want 1", n); end
    if (o.kind !== e.kind) begin failures++; $display("FAIL good_kind: got %b want %b", o.kind, e.kind); end
    if (o.data !== e.data) begin failures++; $display("FAIL good_data: got %h want %h (low word)", o.data[31:0], e.data[31:0]); end
    if (o.data[2047:2040] !== 8'h00) begin failures++; $display("FAIL good_first_byte: got %h want 00", o.data[2047:2040]); end
    if (o.data[7:0] !== 8'hFF) begin failures++; $display("FAIL good_last_byte: got %h want ff", o.data[7:0]); end
    if (o.info !== e.info) begin failures++; $display("FAIL good_ip_info: got %h want %h", o.info, e.info); end
    if (bm !== 1'b1) begin failures++; $display("FAIL good_busy_mid: got %b want 1", bm); end
    if (busy !== 1'b0) begin failures++; $display("FAIL good_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_ip_filter();
    ev_t e, o;
    int n;
    logic bm0, bm1;
    send_frame(local_mac, local_ip + 32'd1, -1, NONE, NONE, bm0);
    exp_q.push_back('{2'b10, pay_model, exp_info()});
    send_frame(local_mac, local_ip, -1, NONE, NONE, bm1);
    settle();
    e = exp_q.pop_front();
    take(o, n);
    checks += 5;
    if (bm0 !== 1'b0) begin failures++; $display("FAIL filter_busy_dropped: got %b want 0", bm0); end
    if (n != 1) begin failures++; $display("FAIL filter_count: got %0d pulses want 1", n); end
    if (o.kind !== e.kind) begin failures++; $display("FAIL filter_next_kind: got %b want %b", o.kind, e.kind); end
    if (o.data !== e.data) begin failures++; $display("FAIL filter_next_data: got %h want %h (low word)", o.data[31:0], e.data[31:0]); end
    if (bm1 !== 1'b1) begin failures++; $display("FAIL filter_next_busy: got %b want 1", bm1); end
  endtask

  task automatic test_broadcast();
    ev_t e, o;
    int n;
    logic bm;
    gap = 1'b1;
    exp_q.push_back('{2'b10, pay_model, exp_info()});
    send_frame(48'hFFFF_FFFF_FFFF, local_ip, -1, NONE, NONE, bm);
    gap = 1'b0;
    settle();
    e = exp_q.pop_front();
    take(o, n);
    checks += 3;
    if (n != 1) begin failures++; $display("FAIL bcast_count: got %0d pulses want 1", n); end
    if (o.kind !== e.kind) begin failures++; $display("FAIL bcast_kind: got %b want %b", o.kind, e.kind); end
    if (o.info !== e.info) begin failures++; $display("FAIL bcast_ip_info: got %h want %h", o.info, e.info); end
  endtask

  task automatic test_truncate();
    ev_t e, o;
    int n;
    logic bm;
    exp_q.push_back('{2'b01, '0, '0});
    send_frame(local_mac, local_ip, -1, 100, NONE, bm);
    settle();
    e = exp_q.pop_front();
    take(o, n);
    checks += 3;
    if (n != 1) begin failures++; $display("FAIL trunc_count: got %0d pulses want 1", n); end
    if (o.kind !== e.kind) begin failures++; $display("FAIL trunc_kind: got %b want %b", o.kind, e.kind); end
    if (busy !== 1'b0) begin failures++; $display("FAIL trunc_busy: got %b want 0", busy); end
  endtask

  task automatic test_crc();
    ev_t e, o;
    int n;
    logic bm;
`ifdef ETH_RX_CRC_CHECK_EN
    exp_q.push_back('{2'b01, '0, '0});
`else
    exp_q.push_back('{2'b10, pay_model, exp_info()});
`endif
    send_frame(local_mac, local_ip, 13, NONE, NONE, bm);
    settle();
    e = exp_q.pop_front();
    take(o, n);
    checks += 2;
    if (n != 1) begin failures++; $display("FAIL crc_count: got %0d pulses want 1", n); end
    if (o.kind !== e.kind) begin failures++; $display("FAIL crc_kind: got %b want %b", o.kind, e.kind); end
  endtask

  task automatic test_reset_mid();
    ev_t e, o;
    int n;
    logic bm;
    send_frame(local_mac, local_ip, -1, NONE, 50, bm);
    settle();
    checks += 4;
    if (obs_q.size() != 0) begin failures++; $display("FAIL rstmid_pulses: got %0d want 0", obs_q.size()); end
    if (data !== '0) begin failures++; $display("FAIL rstmid_data: got %h want 0 (low word)", data[31:0]); end
    if (ip_info !== '0) begin failures++; $display("FAIL rstmid_ip_info: got %h want 0", ip_info); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    obs_q.delete();
    exp_q.push_back('{2'b10, pay_model, exp_info()});
    send_frame(local_mac, local_ip, -1, NONE, NONE, bm);
    settle();
    e = exp_q.pop_front();
    take(o, n);
    checks += 3;
    if (n != 1) begin failures++; $display("FAIL rstmid_next_count: got %0d pulses want 1", n); end
    if (o.kind !== e.kind) begin failures++; $display("FAIL rstmid_next_kind: got %b want %b", o.kind, e.kind); end
    if (o.data !== e.data) begin failures++; $display("FAIL rstmid_next_data: got %h want %h (low word)", o.data[31:0], e.data[31:0]); end
  endtask

  initial begin
    for (int i = 0; i < DB; i++) pay_model[8*DB-1-8*i -: 8] = 8'(i);
    test_reset();
    test_good();
    test_ip_filter();
    test_broadcast();
    test_truncate();
    test_crc();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
